seq_frame_ctrl: RTL

- Frame-level scheduler for the Mono8 sequentializer, one level above it.
- Converts framegrabber start-of-frame (SOF) pulses into ap_start handshakes for the sequentializer, then waits for completion of both the sequentializer and the downstream hls4ml core.
- Drops frames that arrive while busy and guards each frame with a watchdog.
- Exposes frame/drop counters and a sticky timeout error for register readback.

---
 rtl/seq_frame_ctrl_if.sv | 29 ++
 rtl/seq_frame_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/seq_frame_ctrl_if.sv
// Bus bundle between the frame scheduler and its surroundings (framegrabber,
// sequentializer, hls4ml core, register block).
interface seq_frame_ctrl_if #(
    parameter int CNT_W = 16
);
    // seq_ap_start is held while the scheduler is armed; a start is accepted
    // on every rising clk edge where seq_ap_start && seq_ap_ready are both high.
    logic             enable;
    logic             sof;
    logic             seq_ap_start;
    logic             seq_ap_ready;
    logic             seq_ap_done;
    logic             nn_ap_done;
    logic             busy;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] drop_cnt;
    logic             err_timeout;
    logic             err_clear;

    modport master (
        output enable, sof, seq_ap_ready, seq_ap_done, nn_ap_done, err_clear,
        input  seq_ap_start, busy, frame_cnt, drop_cnt, err_timeout
    );

    modport slave (
        input  enable, sof, seq_ap_ready, seq_ap_done, nn_ap_done, err_clear,
        output seq_ap_start, busy, frame_cnt, drop_cnt, err_timeout
    );
endinterface

// File: rtl/seq_frame_ctrl.sv
// Frame scheduler: SOF pulse -> sequentializer ap_start handshake -> wait for
// seq and nn completion, with drop/frame counters and a watchdog.
// Define SEQ_FRAME_CTRL_OVERLAP_EN to let a new frame start while the previous
// one still awaits nn_ap_done.
module seq_frame_ctrl #(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_W           = 20
) (
    input  logic            clk,
    input  logic            reset,
    seq_frame_ctrl_if.slave bus,
    output logic [2:0]      dbg_state_o
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [TO_W-1:0]  WD_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] frame_q, frame_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W:0]   frame_sum;
    logic [TO_W-1:0]  wd_q, wd_d;
    logic             err_q, err_d;
    logic             nn_seen_q, nn_seen_d;
    logic [1:0]       frame_inc;
    logic             drop_inc;
    logic             timeout;
    logic             nn_free;
    logic             wd_run;
`ifdef SEQ_FRAME_CTRL_OVERLAP_EN
    logic             pend_q, pend_d;
`endif

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        nn_seen_d = 1'b0;
        frame_inc = 2'd0;
        drop_inc  = 1'b0;
        timeout   = (wd_q >= WD_LIMIT);
        nn_free   = bus.nn_ap_done;
`ifdef SEQ_FRAME_CTRL_OVERLAP_EN
        // An nn_ap_done is first credited to the frame left pending in flight.
        nn_free   = bus.nn_ap_done && !pend_q;
        pend_d    = pend_q && !bus.nn_ap_done;
        if (pend_q && bus.nn_ap_done) frame_inc = 2'd1;
`endif
        if (bus.err_clear) err_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.sof) begin
                    if (bus.enable) state_d = S_ARM;
                    else            drop_inc = 1'b1;
                end
            end
            S_ARM: begin
                drop_inc = bus.sof;
                if (bus.seq_ap_ready) state_d = S_RUN;
            end
            S_RUN: begin
                drop_inc = bus.sof;
                if (bus.seq_ap_done) begin
                    if (nn_free || nn_seen_q) begin
                        frame_inc = frame_inc + 2'd1;
                        state_d   = S_IDLE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (timeout) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                end else begin
                    nn_seen_d = nn_seen_q || nn_free;
                end
            end
            S_DRAIN: begin
                if (nn_free) begin
                    frame_inc = frame_inc + 2'd1;
                    state_d   = S_IDLE;
                    drop_inc  = bus.sof;
`ifdef SEQ_FRAME_CTRL_OVERLAP_EN
                end else if (bus.sof && bus.enable && !pend_q) begin
                    state_d = S_ARM;
                    pend_d  = 1'b1;
                end else begin
                    drop_inc = bus.sof;
                end
`else
                end else begin
                    drop_inc = bus.sof;
                    if (timeout) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end
                end
`endif
            end
            S_ERROR: begin
                drop_inc = bus.sof;
                if (bus.err_clear) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Watchdog only runs while the frame stays inside the timed states;
        // it saturates at the limit so a late done can still win.
`ifdef SEQ_FRAME_CTRL_OVERLAP_EN
        wd_run = (state_q == S_RUN) && (state_d == S_RUN);
`else
        wd_run = (state_q inside {S_RUN, S_DRAIN}) && (state_d inside {S_RUN, S_DRAIN});
`endif
        wd_d = '0;
        if (wd_run) wd_d = timeout ? wd_q : wd_q + TO_W'(1);

        frame_sum = {1'b0, frame_q} + (CNT_W+1)'(frame_inc);
        frame_d   = frame_sum[CNT_W] ? CNT_MAX : frame_sum[CNT_W-1:0];
        drop_d    = (drop_inc && (drop_q != CNT_MAX)) ? drop_q + CNT_W'(1) : drop_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            frame_q   <= '0;
            drop_q    <= '0;
            wd_q      <= '0;
            err_q     <= 1'b0;
            nn_seen_q <= 1'b0;
`ifdef SEQ_FRAME_CTRL_OVERLAP_EN
            pend_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            drop_q    <= drop_d;
            wd_q      <= wd_d;
            err_q     <= err_d;
            nn_seen_q <= nn_seen_d;
`ifdef SEQ_FRAME_CTRL_OVERLAP_EN
            pend_q    <= pend_d;
`endif
        end
    end

    assign bus.seq_ap_start = (state_q == S_ARM);
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.frame_cnt    = frame_q;
    assign bus.drop_cnt     = drop_q;
    assign bus.err_timeout  = err_q;
    assign dbg_state_o      = state_q;
endmodule
